block_ula_ctrl: RTL and testbench

Sequencer for the stack-machine ALU datapath. It accepts one stack-arithmetic opcode per handshake and performs the full operation:

- reads one or two operands from stack memory;
- loads them into the ALU operand registers;
- drives the ALU mux/op selects;
- writes the result back to the stack and reports the new top-of-stack.

It sits between the instruction decoder (requester) and the ALU block plus stack RAM.

---
 rtl/block_ula_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_block_ula_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_ula_ctrl.sv
// block_ula_ctrl
// Sequencer for the stack-machine ALU datapath. Accepts one stack-arithmetic
// opcode per handshake and walks it through operand reads, operand register
// loads, ALU execution, and result write-back, then reports the new TOS.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   OP_START/OP_CODE/TOS_IN   request from the decoder (sampled only in IDLE)
//   OP_READY                  high only in IDLE
//   OP_DONE/OP_ERR            one-cycle completion pulse and error flag
//   TOS_OUT/TOS_WE            new top-of-stack address and its write strobe
//   STK_RD_EN/STK_RD_ADDR     stack RAM read (data returns one cycle later)
//   STK_WR_EN/STK_WR_ADDR     stack RAM write of ALU_OUT
//   CTRL_REG_*                ALU operand and flag register loads
//   SEL_MUX1/SEL_MUX2/SEL_ULA ALU input and operation selects
// All outputs are registered; they reflect the state the FSM is currently in.
module block_ula_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int STACK_BASE = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  OP_START,
  input  logic [3:0]            OP_CODE,
  input  logic [ADDR_WIDTH-1:0] TOS_IN,
  output logic                  OP_READY,
  output logic                  OP_DONE,
  output logic                  OP_ERR,
  output logic [ADDR_WIDTH-1:0] TOS_OUT,
  output logic                  TOS_WE,
  output logic                  STK_RD_EN,
  output logic [ADDR_WIDTH-1:0] STK_RD_ADDR,
  output logic                  STK_WR_EN,
  output logic [ADDR_WIDTH-1:0] STK_WR_ADDR,
  output logic                  CTRL_REG_OP1,
  output logic                  CTRL_REG_OP2,
  output logic                  CTRL_REG_COMP,
  output logic                  CTRL_REG_OVERFLOW,
  output logic [1:0]            SEL_MUX1,
  output logic [1:0]            SEL_MUX2,
  output logic [3:0]            SEL_ULA
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, LD_B, EXEC, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   BASE_EXT = (ADDR_WIDTH+1)'(STACK_BASE);
  localparam logic [ADDR_WIDTH:0]   ONE_EXT  = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = 1;
  localparam logic [ADDR_WIDTH-1:0] TWO_A    = 2;

  state_t                  state;
  logic [3:0]              op_lat;
  logic [ADDR_WIDTH-1:0]   tos_lat;
  logic                    err_lat;

  function automatic logic is_binary(input logic [3:0] c);
    return c inside {4'b0000, 4'b0001, 4'b0010, 4'b1101, 4'b1110, 4'b1111};
  endfunction

  function automatic logic is_compare(input logic [3:0] c);
    return c inside {4'b1001, 4'b1010, 4'b1011};
  endfunction

  function automatic logic is_unary(input logic [3:0] c);
    return c == 4'b1100;
  endfunction

  function automatic logic loads_overflow(input logic [3:0] c);
    return c inside {4'b0000, 4'b0001, 4'b0010};
  endfunction

  // Underflow is detected from the borrow of a one-bit-wider subtraction, so
  // the check stays well-defined for any STACK_BASE, including 0.
  logic [ADDR_WIDTH:0] tos_ext;
  logic [ADDR_WIDTH:0] margin0;
  logic [ADDR_WIDTH:0] margin1;
  logic                legal;
  logic                underflow;
  logic                accept_ok;
  logic                enter_exec;

  assign tos_ext    = {1'b0, TOS_IN};
  assign margin0    = tos_ext - BASE_EXT;
  assign margin1    = margin0 - ONE_EXT;
  assign legal      = is_binary(OP_CODE) | is_compare(OP_CODE) | is_unary(OP_CODE);
  assign underflow  = is_unary(OP_CODE) ? margin0[ADDR_WIDTH] : margin1[ADDR_WIDTH];
  assign accept_ok  = legal & ~underflow;
  assign enter_exec = (state == LD_B) || ((state == RD_B) && is_unary(op_lat));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      op_lat            <= '0;
      tos_lat           <= '0;
      err_lat           <= 1'b0;
      OP_READY          <= 1'b1;
      OP_DONE           <= 1'b0;
      OP_ERR            <= 1'b0;
      TOS_OUT           <= '0;
      TOS_WE            <= 1'b0;
      STK_RD_EN         <= 1'b0;
      STK_RD_ADDR       <= '0;
      STK_WR_EN         <= 1'b0;
      STK_WR_ADDR       <= '0;
      CTRL_REG_OP1      <= 1'b0;
      CTRL_REG_OP2      <= 1'b0;
      CTRL_REG_COMP     <= 1'b0;
      CTRL_REG_OVERFLOW <= 1'b0;
      SEL_MUX1          <= '0;
      SEL_MUX2          <= '0;
      SEL_ULA           <= '0;
    end else begin
      // Everything deasserts unless the state being entered drives it.
      OP_READY          <= 1'b0;
      OP_DONE           <= 1'b0;
      OP_ERR            <= 1'b0;
      TOS_OUT           <= '0;
      TOS_WE            <= 1'b0;
      STK_RD_EN         <= 1'b0;
      STK_RD_ADDR       <= '0;
      STK_WR_EN         <= 1'b0;
      STK_WR_ADDR       <= '0;
      CTRL_REG_OP1      <= 1'b0;
      CTRL_REG_OP2      <= 1'b0;
      CTRL_REG_COMP     <= 1'b0;
      CTRL_REG_OVERFLOW <= 1'b0;
      SEL_MUX1          <= '0;
      SEL_MUX2          <= '0;
      SEL_ULA           <= '0;

      case (state)
        IDLE: begin
          if (OP_START) begin
            op_lat  <= OP_CODE;
            tos_lat <= TOS_IN;
            if (accept_ok) begin
              err_lat     <= 1'b0;
              state       <= RD_A;
              STK_RD_EN   <= 1'b1;
              STK_RD_ADDR <= TOS_IN;
            end else begin
              // Rejected ops complete immediately with no datapath activity.
              err_lat <= 1'b1;
              state   <= DONE;
              OP_DONE <= 1'b1;
              OP_ERR  <= 1'b1;
            end
          end else begin
            OP_READY <= 1'b1;
          end
        end
        RD_A: begin
          // Operand A arrives on the bus in RD_B; B is fetched in the same cycle.
          state        <= RD_B;
          CTRL_REG_OP1 <= 1'b1;
          if (!is_unary(op_lat)) begin
            STK_RD_EN   <= 1'b1;
            STK_RD_ADDR <= tos_lat - ONE_A;
          end
        end
        RD_B: begin
          if (!is_unary(op_lat)) begin
            state        <= LD_B;
            CTRL_REG_OP2 <= 1'b1;
          end
        end
        LD_B: ;
        EXEC: begin
          state   <= DONE;
          OP_DONE <= 1'b1;
          OP_ERR  <= err_lat;
          if (!err_lat) begin
            TOS_WE <= 1'b1;
            if (is_unary(op_lat))
              TOS_OUT <= tos_lat;
            else if (is_compare(op_lat))
              TOS_OUT <= tos_lat - TWO_A;
            else
              TOS_OUT <= tos_lat - ONE_A;
          end
        end
        DONE: begin
          state    <= IDLE;
          OP_READY <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          OP_READY <= 1'b1;
        end
      endcase

      // Entering EXEC: selects, flag loads and write-back share one cycle.
      if (enter_exec) begin
        state             <= EXEC;
        SEL_MUX1          <= 2'b11;
        SEL_MUX2          <= 2'b11;
        SEL_ULA           <= op_lat;
        CTRL_REG_OVERFLOW <= loads_overflow(op_lat);
        CTRL_REG_COMP     <= is_compare(op_lat);
        if (is_binary(op_lat)) begin
          STK_WR_EN   <= 1'b1;
          STK_WR_ADDR <= tos_lat - ONE_A;
        end else if (is_unary(op_lat)) begin
          STK_WR_EN   <= 1'b1;
          STK_WR_ADDR <= tos_lat;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_ula_ctrl.sv
// Directed-vector bench for block_ula_ctrl, with a small stack RAM and ALU
// model attached to the sequencer's strobes.
module tb_block_ula_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        OP_START;
  logic [3:0]  OP_CODE;
  logic [11:0] TOS_IN;
  logic        OP_READY, OP_DONE, OP_ERR, TOS_WE;
  logic [11:0] TOS_OUT, STK_RD_ADDR, STK_WR_ADDR;
  logic        STK_RD_EN, STK_WR_EN;
  logic        CTRL_REG_OP1, CTRL_REG_OP2, CTRL_REG_COMP, CTRL_REG_OVERFLOW;
  logic [1:0]  SEL_MUX1, SEL_MUX2;
  logic [3:0]  SEL_ULA;

  always #5 clk = ~clk;

  block_ula_ctrl #(.ADDR_WIDTH(12), .STACK_BASE(0)) dut (
    .clk(clk), .reset_n(reset_n), .OP_START(OP_START), .OP_CODE(OP_CODE),
    .TOS_IN(TOS_IN), .OP_READY(OP_READY), .OP_DONE(OP_DONE), .OP_ERR(OP_ERR),
    .TOS_OUT(TOS_OUT), .TOS_WE(TOS_WE), .STK_RD_EN(STK_RD_EN),
    .STK_RD_ADDR(STK_RD_ADDR), .STK_WR_EN(STK_WR_EN), .STK_WR_ADDR(STK_WR_ADDR),
    .CTRL_REG_OP1(CTRL_REG_OP1), .CTRL_REG_OP2(CTRL_REG_OP2),
    .CTRL_REG_COMP(CTRL_REG_COMP), .CTRL_REG_OVERFLOW(CTRL_REG_OVERFLOW),
    .SEL_MUX1(SEL_MUX1), .SEL_MUX2(SEL_MUX2), .SEL_ULA(SEL_ULA)
  );

  // Stack RAM and ALU model
  logic [7:0]  ram [4096];
  logic [7:0]  rd_bus, reg_op1, reg_op2, alu_out;
  logic        comp_reg;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;

  always_comb begin
    alu_out = '0;
    case (SEL_ULA)
      4'b0000: alu_out = reg_op2 + reg_op1;
      4'b0001: alu_out = reg_op2 - reg_op1;
      4'b0010: alu_out = reg_op2 * reg_op1;
      4'b1101: alu_out = reg_op2 & reg_op1;
      4'b1110: alu_out = reg_op2 | reg_op1;
      4'b1111: alu_out = reg_op2 ^ reg_op1;
      4'b1100: alu_out = ~reg_op1;
      4'b1001: alu_out = {7'd0, reg_op2 == reg_op1};
      4'b1010: alu_out = {7'd0, reg_op2 <  reg_op1};
      4'b1011: alu_out = {7'd0, reg_op2 >  reg_op1};
      default: alu_out = '0;
    endcase
  end

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (STK_WR_EN) ram[STK_WR_ADDR] <= alu_out;
    if (STK_RD_EN) rd_bus <= ram[STK_RD_ADDR];
    if (CTRL_REG_OP1) reg_op1 <= rd_bus;
    if (CTRL_REG_OP2) reg_op2 <= rd_bus;
    if (CTRL_REG_COMP) comp_reg <= alu_out[0];
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (OP_READY) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wait_ready", 0, 1);
  endtask

  function automatic logic [9:0] flags();
    return {OP_READY, OP_DONE, OP_ERR, TOS_WE, STK_RD_EN, STK_WR_EN,
            CTRL_REG_OP1, CTRL_REG_OP2, CTRL_REG_COMP, CTRL_REG_OVERFLOW};
  endfunction

  // Per-operation observations; cycle 1 is the cycle right after acceptance.
  int          n_rd, n_op1, n_op2, n_wr, n_ovf, n_cmp, n_twe;
  int          done_cyc, ovf_cyc, cmp_cyc, wr_cyc, sel_cyc;
  logic [11:0] wr_addr, tos_out_s, rd_addr2;
  logic [7:0]  wr_data, sel_s;
  logic        err_s;

  task automatic run_op(input logic [3:0] code, input logic [11:0] tos);
    wait_ready();
    n_rd = 0; n_op1 = 0; n_op2 = 0; n_wr = 0; n_ovf = 0; n_cmp = 0; n_twe = 0;
    done_cyc = 0; ovf_cyc = 0; cmp_cyc = 0; wr_cyc = 0; sel_cyc = 0;
    wr_addr = '0; tos_out_s = '0; rd_addr2 = '0; wr_data = '0; sel_s = '0; err_s = 1'b0;
    OP_CODE = code; TOS_IN = tos; OP_START = 1'b1;
    @(posedge clk); #1;
    OP_START = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (STK_RD_EN) begin n_rd++; if (n_rd == 2) rd_addr2 = STK_RD_ADDR; end
      if (CTRL_REG_OP1) n_op1++;
      if (CTRL_REG_OP2) n_op2++;
      if (CTRL_REG_OVERFLOW) begin n_ovf++; ovf_cyc = c; end
      if (CTRL_REG_COMP) begin n_cmp++; cmp_cyc = c; end
      if (STK_WR_EN) begin n_wr++; wr_cyc = c; wr_addr = STK_WR_ADDR; wr_data = alu_out; end
      if (SEL_MUX1 == 2'b11) begin sel_cyc = c; sel_s = {SEL_MUX1, SEL_MUX2, SEL_ULA}; end
      if (TOS_WE) begin n_twe++; tos_out_s = TOS_OUT; end
      if (OP_DONE) begin done_cyc = c; err_s = OP_ERR; break; end
      @(posedge clk); #1;
    end
  endtask

  int n_done;

  initial begin
    reset_n = 1'b0; OP_START = 1'b0; OP_CODE = '0; TOS_IN = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 32'(flags()), 32'h200);
    chk("rst_sels", 32'({SEL_MUX1, SEL_MUX2, SEL_ULA}), 0);
    chk("rst_addrs", 32'(TOS_OUT | STK_RD_ADDR | STK_WR_ADDR), 0);
    reset_n = 1'b1;

    // ADD: 7 + 3
    poke(12'd5, 8'd3); poke(12'd4, 8'd7);
    run_op(4'b0000, 12'd5);
    chk("add_done_cyc", done_cyc, 5);
    chk("add_err", 32'(err_s), 0);
    chk("add_rd_cnt", n_rd, 2);
    chk("add_rd_addr_b", 32'(rd_addr2), 4);
    chk("add_wr_cnt", n_wr, 1);
    chk("add_wr_cyc", wr_cyc, 4);
    chk("add_wr_addr", 32'(wr_addr), 4);
    chk("add_wr_data", 32'(wr_data), 10);
    chk("add_sel", 32'(sel_s), 32'hF0);
    chk("add_sel_cyc", sel_cyc, 4);
    chk("add_tos_we", n_twe, 1);
    chk("add_tos_out", 32'(tos_out_s), 4);
    chk("add_ram4", 32'(ram[4]), 10);

    // SUB: (TOS-1) - TOS = 2 - 9
    poke(12'd5, 8'd9); poke(12'd4, 8'd2);
    run_op(4'b0001, 12'd5);
    chk("sub_done_cyc", done_cyc, 5);
    chk("sub_wr_addr", 32'(wr_addr), 4);
    chk("sub_wr_data", 32'(wr_data), 32'hF9);
    chk("sub_ovf_cnt", n_ovf, 1);
    chk("sub_ovf_cyc", ovf_cyc, 4);
    chk("sub_sel", 32'(sel_s), 32'hF1);

    // Compare equal 6 / 6
    poke(12'd5, 8'd6); poke(12'd4, 8'd6);
    run_op(4'b1001, 12'd5);
    chk("cmp_done_cyc", done_cyc, 5);
    chk("cmp_comp_cnt", n_cmp, 1);
    chk("cmp_comp_cyc", cmp_cyc, 4);
    chk("cmp_comp_reg", 32'(comp_reg), 1);
    chk("cmp_wr_cnt", n_wr, 0);
    chk("cmp_ovf_cnt", n_ovf, 0);
    chk("cmp_tos_out", 32'(tos_out_s), 3);

    // Unary NOT at the stack base
    poke(12'd0, 8'h0F);
    run_op(4'b1100, 12'd0);
    chk("not_done_cyc", done_cyc, 4);
    chk("not_rd_cnt", n_rd, 1);
    chk("not_op1_cnt", n_op1, 1);
    chk("not_op2_cnt", n_op2, 0);
    chk("not_wr_addr", 32'(wr_addr), 0);
    chk("not_wr_data", 32'(wr_data), 32'hF0);
    chk("not_tos_out", 32'(tos_out_s), 0);
    chk("not_ram0", 32'(ram[0]), 32'hF0);

    // Illegal opcode
    run_op(4'b0110, 12'd5);
    chk("ill_done_cyc", done_cyc, 1);
    chk("ill_err", 32'(err_s), 1);
    chk("ill_strobes", n_rd + n_wr + n_twe + n_op1 + n_op2 + n_ovf + n_cmp, 0);

    // Binary underflow at the stack base
    run_op(4'b0000, 12'd0);
    chk("unf_done_cyc", done_cyc, 1);
    chk("unf_err", 32'(err_s), 1);
    chk("unf_strobes", n_rd + n_wr + n_twe + n_op1 + n_op2 + n_ovf + n_cmp, 0);

    // Compare at TOS=1: new TOS wraps to the top of the address space
    poke(12'd1, 8'd3); poke(12'd0, 8'd5);
    run_op(4'b1011, 12'd1);
    chk("wrap_done_cyc", done_cyc, 5);
    chk("wrap_err", 32'(err_s), 0);
    chk("wrap_tos_out", 32'(tos_out_s), 32'hFFF);
    chk("wrap_comp_reg", 32'(comp_reg), 1);

    // Busy request ignored, then reset during EXEC
    poke(12'd8, 8'd1); poke(12'd7, 8'd2);
    wait_ready();
    OP_CODE = 4'b0000; TOS_IN = 12'd8; OP_START = 1'b1;
    @(posedge clk); #1;
    OP_START = 1'b0;
    chk("busy_rda_rd", 32'(STK_RD_EN), 1);
    @(posedge clk); #1;
    chk("busy_rdb_op1", 32'(CTRL_REG_OP1), 1);
    OP_START = 1'b1; OP_CODE = 4'b0110;
    @(posedge clk); #1;
    OP_START = 1'b0; OP_CODE = 4'b0000;
    chk("busy_ldb_flags", 32'(flags()), 32'h004);
    @(posedge clk); #1;
    chk("busy_exec_wr", 32'(STK_WR_EN), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_flags", 32'(flags()), 32'h200);
    chk("arst_sels", 32'({SEL_MUX1, SEL_MUX2, SEL_ULA}), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (OP_DONE) n_done++;
    end
    chk("arst_no_done", n_done, 0);
    chk("arst_ready", 32'(OP_READY), 1);
    chk("arst_no_write", 32'(ram[7]), 2);

    run_op(4'b0000, 12'd8);
    chk("post_done_cyc", done_cyc, 5);
    chk("post_err", 32'(err_s), 0);
    chk("post_ram7", 32'(ram[7]), 3);
    chk("post_tos_out", 32'(tos_out_s), 7);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
